// File: rtl/spi_host_merge_arb.sv
// Segment-locked round-robin arbiter in front of the SPI host RX byte-merge stage.
// A granted requester owns the merge input until its last byte (real or forced) is accepted.
module spi_host_merge_arb #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxSegBytes = 4096,
  parameter int unsigned CntW        = $clog2(MaxSegBytes + 1),
  parameter int unsigned IdW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_rst_i,
  input  logic [8*NumReq-1:0] req_byte_i,
  input  logic [NumReq-1:0]   req_last_i,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic [7:0]          merge_byte_o,
  output logic                merge_last_o,
  output logic                merge_valid_o,
  input  logic                merge_ready_i,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o,
  output logic [CntW-1:0]     seg_count_o,
  output logic                seg_done_o,
  output logic [IdW-1:0]      seg_done_id_o,
  output logic                overflow_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d, sel_onehot;
  logic [IdW-1:0]    gidx_q, gidx_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    done_id_q, done_id_d;
  logic [IdW-1:0]    sel_idx;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              rst, locked, sel_found, force_last, xfer;
  logic [7:0]        g_byte;
  logic              g_last, g_valid;

  assign rst        = rst_i | sw_rst_i;
  assign locked     = (state_q == LOCKED);
  assign force_last = (cnt_q == CntW'(MaxSegBytes - 1));

  // Round-robin search starting at ptr_q; offset loop outer so the first hit wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (!sel_found && ((32'(ptr_q) + i) % NumReq == j) && req_valid_i[j]) begin
          sel_found = 1'b1;
          sel_idx   = IdW'(j);
        end
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      sel_onehot[j] = (32'(sel_idx) == j);
    end
  end

  always_comb begin
    g_byte  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (grant_q[j]) begin
        g_byte  = req_byte_i[8*j +: 8];
        g_last  = req_last_i[j];
        g_valid = req_valid_i[j];
      end
    end
  end

  assign merge_byte_o  = g_byte;
  assign merge_last_o  = locked & (g_last | force_last);
  assign merge_valid_o = locked & g_valid & ~rst;
  assign req_ready_o   = (locked && !rst) ? (grant_q & {NumReq{merge_ready_i}}) : '0;
  assign xfer          = merge_valid_o & merge_ready_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCKED;
          grant_d = sel_onehot;
          gidx_d  = sel_idx;
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (merge_last_o) begin
            state_d   = IDLE;
            grant_d   = '0;
            cnt_d     = '0;
            ptr_d     = (32'(gidx_q) == NumReq - 1) ? '0 : gidx_q + IdW'(1);
            done_d    = 1'b1;
            done_id_d = gidx_q;
            ovf_d     = ovf_q | (force_last & ~g_last);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      ovf_q     <= ovf_d;
    end
  end

  assign grant_o       = grant_q;
  assign busy_o        = locked;
  assign seg_count_o   = cnt_q;
  assign seg_done_o    = done_q;
  assign seg_done_id_o = done_id_q;
  assign overflow_o    = ovf_q;

endmodule

// File: doc/spi_host_merge_arb.md
Name: spi_host_merge_arb

Overview:
- Segment-locked round-robin arbiter that shares one byte-merge/packer input (8-bit byte, last, valid/ready) among NumReq byte sources, e.g. the RX shift path and a loopback/diagnostic source.
- Once a requester is granted, it owns the merge input until the byte flagged last is accepted, so one segment's bytes are never interleaved with another's.
- Sits directly upstream of the byte-merge stage in the SPI host RX datapath.
- Also counts bytes per segment and truncates runaway segments.

Parameters:
- NumReq, 2, number of byte requesters (2..8).
- MaxSegBytes, 4096, maximum bytes per segment before forced termination.
- CntW, $clog2(MaxSegBytes+1), width of the segment byte counter (derived, not overridden).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- sw_rst_i  input  1  software reset; same effect as rst_i.
- req_byte_i  input  8*NumReq  byte from each requester; requester k on bits [8k+7:8k].
- req_last_i  input  NumReq  last-byte-of-segment flag per requester.
- req_valid_i  input  NumReq  byte valid per requester.
- req_ready_o  output  NumReq  byte accepted per requester.
- merge_byte_o  output  8  byte to the byte-merge stage.
- merge_last_o  output  1  last flag to the byte-merge stage.
- merge_valid_o  output  1  valid to the byte-merge stage.
- merge_ready_i  input  1  ready from the byte-merge stage.
- grant_o  output  NumReq  one-hot current owner; all zero when idle.
- busy_o  output  1  a segment is in progress.
- seg_count_o  output  CntW  bytes accepted in the current segment.
- seg_done_o  output  1  one-cycle pulse: a segment completed.
- seg_done_id_o  output  $clog2(NumReq)  requester index of the completed segment; valid while seg_done_o is high.
- overflow_o  output  1  sticky: a segment was force-terminated at MaxSegBytes.

Behaviour:
Reset:
- rst_i or sw_rst_i at a clock edge sets state=IDLE and clears grant_o, busy_o, seg_count_o, seg_done_o, seg_done_id_o, overflow_o and the RR pointer (ptr=0).
- While sw_rst_i or rst_i is high, req_ready_o=0 and merge_valid_o=0 combinationally.
- A segment cut by a reset is abandoned; no last byte is synthesised.

Handshake:
- A transfer occurs when merge_valid_o && merge_ready_i.
- Requesters must hold byte, last and valid stable until ready.

FSM states: IDLE, LOCKED.
- IDLE:
  - merge_valid_o=0 and req_ready_o=0.
  - If any req_valid_i bit is set, select the first set bit searching ptr, ptr+1, … with modulo-NumReq wrap.
  - Register the one-hot grant and go to LOCKED next cycle.
  - Arbitration costs exactly 1 idle cycle per segment.
- LOCKED, granted index g:
  - merge_byte_o = req_byte_i[g].
  - merge_valid_o = req_valid_i[g].
  - merge_last_o = req_last_i[g] | force_last.
  - req_ready_o[g] = merge_ready_i; all other req_ready_o bits are 0.
  - Path is pass-through combinational; zero latency.
  - Each transfer increments seg_count_o.
  - force_last = (seg_count_o == MaxSegBytes-1).
  - On a transfer with merge_last_o=1:
    - next cycle: state=IDLE, grant_o=0, seg_count_o=0, ptr=(g+1) mod NumReq.
    - seg_done_o pulses for exactly 1 cycle with seg_done_id_o=g.
    - If force_last was set and req_last_i[g] was 0, overflow_o sets; it clears only on reset.
  - After a forced termination, the requester's following bytes start a new segment when next granted.
- Stalls: merge_ready_i low in LOCKED holds all state; the grant never times out.

Outputs:
- busy_o = (state==LOCKED).
- seg_count_o is registered; it shows bytes accepted before the current cycle.

Boundary conditions:
- Simultaneous valids in IDLE: the RR pointer decides.
- A requester whose valid drops in LOCKED keeps the grant.
- A segment with last on its first byte gives seg_count 0→0 and a seg_done pulse.
- With NumReq=1, the block degenerates to a pass-through plus 1 idle cycle per segment.

Test Plan:
1. Reset, then req0 sends 4 bytes 0xA1..0xA4 with last on 0xA4, merge_ready_i=1:
   - grant_o=01 one cycle after valid.
   - Bytes forwarded in order, merge_last_o on 0xA4.
   - seg_done_o one pulse with id 0; seg_count_o reaches 3 before clearing to 0.
2. req0 and req1 both valid continuously with 2-byte segments:
   - grants alternate 01,10,01,10.
   - No byte of req1 appears between req0's first and last byte.
3. Mid-segment merge_ready_i low for 5 cycles:
   - req_ready_o=0 and merge_byte_o held.
   - seg_count_o unchanged.
   - Resumes with no byte lost or duplicated.
4. MaxSegBytes=8, req1 sends 10 bytes without last:
   - merge_last_o forced on byte 8.
   - seg_done_o with id 1 and overflow_o=1.
   - Bytes 9–10 form a new segment after re-grant.
5. sw_rst_i asserted after 2 bytes of a segment:
   - same cycle: req_ready_o=0 and merge_valid_o=0.
   - next cycle: grant_o=0, seg_count_o=0, overflow_o=0, no seg_done_o pulse.
   - Next arbitration starts from requester 0.
